rv_fanctl: RTL
==============

# rv_fanctl

Closed-loop fan controller sitting beside the sysmon ADC interface on the rv32 peripheral bus. It consumes the sysmon conversion stream, averages the die-temperature channel, and derives a fan duty with hysteresis and slew limiting. It drives the 8-bit duty consumed by the fan PWM generator and monitors the fan tachometer for stall. Software can read status over the bus or override the duty manually.

## Interface
Parameters:
- STEP_DIV, 65536: clk cycles per slew step (≥2).
- TACH_WIN, 10_000_000: clk cycles per tach measurement window (≥2).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high; one clock, and reset is synchronous and active-high.
- adr  in  5  byte address; word select = adr[4:2].
- cs  in  1  block select.
- rdy  in  1  bus advance strobe.
- we  in  4  byte write enables.
- re  in  1  read enable.
- dw  in  32  write data.
- dr  out  32  read data; 0 when not reading.
- eoc_in  in  1  sysmon end-of-conversion pulse.
- channel_in  in  6  sysmon channel of current conversion.
- adc_data_in  in  16  sysmon conversion result.
- tach_in  in  1  asynchronous fan tach pulse.
- duty_out  out  8  fan duty (0 = off, 255 = full).
- stall_out  out  1  sticky stall flag.

## Operation
- Registers (write when cs && rdy && we[i] for byte i):
  - W0 RW: [0] auto_en (rst 1), [10:8] gain (rst 2), [23:16] manual duty (rst 0x80).
  - W1 RW: [9:0] t_lo (rst 0x299 ≈ 50 °C), [25:16] t_hi (rst 0x2D5 ≈ 80 °C).
  - W2 RW: [7:0] min_duty (rst 0x40), [13:8] hyst (rst 8).
  - W3 RO: [9:0] temp_avg, [17:16] state (0 OFF, 1 ON, 2 FULL), [31:24] duty_out.
  - W4: [15:0] tach_count RO, [31] stall; writing 1 to bit 31 with we[3] clears it.
  - W5–W7 read 0.
- Read path: on rdy, latch re1 <= cs && re and adr1 <= adr. dr = re1 ? word[adr1[4:2]] : 0.
- Averaging:
  - On eoc_in && channel_in == 0, add adc_data_in[15:6] to a 13-bit accumulator and increment a 3-bit count.
  - On the 8th sample, temp_avg <= (acc + sample) >> 3; clear acc and count.
  - Raise avg_upd for one cycle.
- FSM, evaluated only on the avg_upd cycle, using the register values held before any same-cycle bus write:
  - OFF: go to FULL if avg ≥ t_hi; else go to ON if avg ≥ t_lo.
  - ON: go to FULL if avg ≥ t_hi; go to OFF if avg + hyst < t_lo.
  - FULL: go to ON if avg + hyst < t_hi.
  - Compare in 11 bits (no wrap).
- Target duty:
  - Manual mode (auto_en = 0): target = manual. The FSM keeps running.
  - Auto, OFF: 0.
  - Auto, FULL: 255.
  - Auto, ON: min_duty + ((avg − t_lo) << gain), computed in 18 bits and saturated at 255. If avg < t_lo (hysteresis band), target = min_duty.
- Slew: a prescaler pulses step every STEP_DIV cycles. On step, duty_out moves one LSB toward target; it holds when equal.
- Tach:
  - tach_in passes through a 2-flop synchronizer, then rising-edge detection.
  - Edges are counted in 16 bits, saturating at 0xFFFF.
  - At window end (every TACH_WIN cycles): tach_count <= edge count, and the counter clears. An edge on the end cycle counts into the next window.
  - A window end with 0 edges while duty_out ≠ 0 increments the miss count; any other window end clears it. On reaching 2 misses, set stall.
  - stall_out = stall.

## Timing
- Reset values: dr = 0, duty_out = 0, stall_out = 0, state OFF, temp_avg = 0, tach_count = 0, accumulator, prescalers and miss count = 0, plus the register defaults above.
- Reset mid-operation discards partial averages and windows.
- temp_avg is valid 1 cycle after the 8th qualifying eoc_in. The FSM state and target follow 1 cycle later.
- duty_out changes only on step cycles: 1 LSB per STEP_DIV cycles. Full-scale slew takes 255·STEP_DIV cycles.
- Register writes take effect the next cycle.
- Read data appears on dr in the cycle after the rdy cycle that latched the access.
- A stall clear in the same cycle as a stall set leaves stall = 1.
- tach_in-to-counter latency is 3 cycles.

## Test plan
- Reset, then read W0/W1/W2 → 0x0002_0201? No: W0 = 0x0080_0201, W1 = 0x02D5_0299, W2 = 0x0000_0840. duty_out = 0, stall_out = 0.
- STEP_DIV = 4. Feed 8 channel-0 samples with code 0x2A9 (avg 681) → state ON, target = 0x40 + (16 << 2) = 0x80. duty_out ramps 0 → 0x80 at one LSB per 4 cycles.
- From ON: avg 0x2D5 → FULL, ramps to 255. Then avg 0x2D0 → stays FULL. Then avg 0x2CC → ON.
- Samples on channels ≠ 0 are ignored (temp_avg unchanged). A W1 write on the avg_upd cycle: FSM uses old thresholds.
- Write auto_en = 0 with manual = 0x10 → duty_out slews to 0x10 regardless of temperature. W3 state keeps tracking.
- TACH_WIN = 100. Drive 5 tach pulses per window → W4 count = 5. Stop pulses with duty ≠ 0 → stall_out rises at the 2nd empty window end. Write W4 bit 31 = 1 → stall_out clears.

Source files
------------

// File: rtl/rv_fanctl.sv
// rv_fanctl: closed-loop fan controller. Averages the sysmon die-temperature
// channel, runs an OFF/ON/FULL hysteresis FSM and slews an 8-bit fan duty
// toward a target. Also measures the fan tachometer and flags a stall.
// Ports:
//   clk, reset         : clock, synchronous active-high reset
//   adr, cs, rdy, we,  : rv32 peripheral bus (word select adr[4:2],
//   re, dw, dr         :   byte write enables, registered read data)
//   eoc_in, channel_in,: sysmon conversion stream
//   adc_data_in        :
//   tach_in            : asynchronous fan tach pulse
//   duty_out           : fan duty to the PWM generator
//   stall_out          : sticky stall flag
module rv_fanctl #(
    parameter int STEP_DIV = 65536,
    parameter int TACH_WIN = 10_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  adr,
    input  logic        cs,
    input  logic        rdy,
    input  logic [3:0]  we,
    input  logic        re,
    input  logic [31:0] dw,
    output logic [31:0] dr,
    input  logic        eoc_in,
    input  logic [5:0]  channel_in,
    input  logic [15:0] adc_data_in,
    input  logic        tach_in,
    output logic [7:0]  duty_out,
    output logic        stall_out
);

    localparam int SW = $clog2(STEP_DIV);
    localparam int TW = $clog2(TACH_WIN);
    localparam logic [SW-1:0] STEP_LAST = SW'(STEP_DIV - 1);
    localparam logic [TW-1:0] WIN_LAST  = TW'(TACH_WIN - 1);

    typedef enum logic [1:0] {
        S_OFF  = 2'd0,
        S_ON   = 2'd1,
        S_FULL = 2'd2
    } state_t;

    // configuration registers
    logic       auto_en;
    logic [2:0] gain;
    logic [7:0] manual;
    logic [9:0] t_lo;
    logic [9:0] t_hi;
    logic [7:0] min_duty;
    logic [5:0] hyst;

    logic       wr;
    logic [2:0] wsel;
    logic       stall_clr;

    assign wr        = cs && rdy;
    assign wsel      = adr[4:2];
    assign stall_clr = wr && (wsel == 3'd4) && we[3] && dw[31];

    always_ff @(posedge clk) begin
        if (reset) begin
            auto_en  <= 1'b1;
            gain     <= 3'd2;
            manual   <= 8'h80;
            t_lo     <= 10'h299;
            t_hi     <= 10'h2D5;
            min_duty <= 8'h40;
            hyst     <= 6'd8;
        end else if (wr) begin
            if (wsel == 3'd0) begin
                if (we[0]) auto_en <= dw[0];
                if (we[1]) gain    <= dw[10:8];
                if (we[2]) manual  <= dw[23:16];
            end
            if (wsel == 3'd1) begin
                if (we[0]) t_lo[7:0] <= dw[7:0];
                if (we[1]) t_lo[9:8] <= dw[9:8];
                if (we[2]) t_hi[7:0] <= dw[23:16];
                if (we[3]) t_hi[9:8] <= dw[25:24];
            end
            if (wsel == 3'd2) begin
                if (we[0]) min_duty <= dw[7:0];
                if (we[1]) hyst     <= dw[13:8];
            end
        end
    end

    // temperature averaging over 8 channel-0 samples
    logic [12:0] acc;
    logic [2:0]  cnt;
    logic [9:0]  temp_avg;
    logic        avg_upd;
    logic [9:0]  sample;
    logic [12:0] acc_sum;

    assign sample  = adc_data_in[15:6];
    assign acc_sum = acc + {3'b0, sample};

    always_ff @(posedge clk) begin
        if (reset) begin
            acc      <= '0;
            cnt      <= '0;
            temp_avg <= '0;
            avg_upd  <= 1'b0;
        end else begin
            avg_upd <= 1'b0;
            if (eoc_in && channel_in == 6'd0) begin
                if (cnt == 3'd7) begin
                    temp_avg <= acc_sum[12:3];
                    acc      <= '0;
                    cnt      <= '0;
                    avg_upd  <= 1'b1;
                end else begin
                    acc <= acc_sum;
                    cnt <= cnt + 3'd1;
                end
            end
        end
    end

    // hysteresis FSM
    state_t      state;
    state_t      state_nx;
    logic [10:0] avg_x;
    logic [10:0] avg_h;
    logic [10:0] lo_x;
    logic [10:0] hi_x;

    assign avg_x = {1'b0, temp_avg};
    assign avg_h = avg_x + {5'b0, hyst};
    assign lo_x  = {1'b0, t_lo};
    assign hi_x  = {1'b0, t_hi};

    always_ff @(posedge clk) begin
        if (reset) state <= S_OFF;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (avg_upd) begin
            case (state)
                S_OFF: begin
                    if (avg_x >= hi_x)      state_nx = S_FULL;
                    else if (avg_x >= lo_x) state_nx = S_ON;
                end
                S_ON: begin
                    if (avg_x >= hi_x)      state_nx = S_FULL;
                    else if (avg_h < lo_x)  state_nx = S_OFF;
                end
                S_FULL: begin
                    if (avg_h < hi_x)       state_nx = S_ON;
                end
                default: state_nx = S_OFF;
            endcase
        end
    end

    // target duty; 18-bit math so a gain of 7 on a full-range delta cannot wrap
    logic [7:0]  target;
    logic [17:0] diff18;
    logic [17:0] sum18;

    assign diff18 = {8'b0, temp_avg} - {8'b0, t_lo};
    assign sum18  = {10'b0, min_duty} + (diff18 << gain);

    always_comb begin
        target = '0;
        if (!auto_en) begin
            target = manual;
        end else begin
            case (state)
                S_FULL: target = 8'hFF;
                S_ON: begin
                    if (avg_x < lo_x)         target = min_duty;
                    else if (sum18 > 18'd255) target = 8'hFF;
                    else                      target = sum18[7:0];
                end
                default: target = 8'h00;
            endcase
        end
    end

    // slew limiter
    logic [SW-1:0] pre;
    logic          step;

    assign step = (pre == STEP_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            pre      <= '0;
            duty_out <= '0;
        end else begin
            pre <= step ? '0 : pre + 1'b1;
            if (step) begin
                if (duty_out < target)      duty_out <= duty_out + 8'd1;
                else if (duty_out > target) duty_out <= duty_out - 8'd1;
            end
        end
    end

    // tachometer: synchronizer, edge detect, windowed count, stall detect
    logic          ts1;
    logic          ts2;
    logic          ts3;
    logic          tedge;
    logic [TW-1:0] wcnt;
    logic          win_end;
    logic [15:0]   edge_cnt;
    logic [15:0]   tach_count;
    logic [1:0]    miss;
    logic          stall;

    assign tedge   = ts2 && !ts3;
    assign win_end = (wcnt == WIN_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            ts1 <= 1'b0;
            ts2 <= 1'b0;
            ts3 <= 1'b0;
        end else begin
            ts1 <= tach_in;
            ts2 <= ts1;
            ts3 <= ts2;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wcnt       <= '0;
            edge_cnt   <= '0;
            tach_count <= '0;
            miss       <= '0;
            stall      <= 1'b0;
        end else begin
            wcnt <= win_end ? '0 : wcnt + 1'b1;
            if (stall_clr) stall <= 1'b0;
            if (win_end) begin
                tach_count <= edge_cnt;
                edge_cnt   <= tedge ? 16'd1 : 16'd0;
                if (edge_cnt == 16'd0 && duty_out != 8'd0) begin
                    if (miss != 2'd2) miss <= miss + 2'd1;
                    // a set here overrides a same-cycle clear
                    if (miss != 2'd0) stall <= 1'b1;
                end else begin
                    miss <= '0;
                end
            end else if (tedge && edge_cnt != 16'hFFFF) begin
                edge_cnt <= edge_cnt + 16'd1;
            end
        end
    end

    assign stall_out = stall;

    // registered read path
    logic       re1;
    logic [4:0] adr1;

    always_ff @(posedge clk) begin
        if (reset) begin
            re1  <= 1'b0;
            adr1 <= '0;
        end else if (rdy) begin
            re1  <= cs && re;
            adr1 <= adr;
        end
    end

    always_comb begin
        dr = '0;
        if (re1) begin
            case (adr1[4:2])
                3'd0: dr = {8'b0, manual, 5'b0, gain, 7'b0, auto_en};
                3'd1: dr = {6'b0, t_hi, 6'b0, t_lo};
                3'd2: dr = {18'b0, hyst, min_duty};
                3'd3: dr = {duty_out, 6'b0, state, 6'b0, temp_avg};
                3'd4: dr = {stall, 15'b0, tach_count};
                default: dr = '0;
            endcase
        end
    end

    logic unused_bits;
    assign unused_bits = ^{dw[30:26], dw[15:14], adc_data_in[5:0], adr[1:0],
                           adr1[1:0]};

endmodule
